sp_ram_master: RTL

Initiator-side controller for the single-port RAM with the shared bidirectional data bus.
- Upstream: accepts read or write burst requests over a valid/ready handshake.
- RAM side: sequences the en, wr, adder and data pins, including bus turnaround.
- Returns read data as a registered stream.
- Sits between any requesting logic and a single_port_ram instance, so no other block drives the inout bus.

---
 rtl/sp_ram_pkg.sv | 18 +
 rtl/burst_counter.sv | 54 +++++
 rtl/sp_ram_master.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sp_ram_pkg.sv
// sp_ram_pkg
// Shared definitions for the single-port RAM initiator.
//   state_e    : controller states (IDLE, WRITE, READ, DRAIN)
//   ADDR_W_DEF : default RAM address width
//   DATA_W_DEF : default RAM data width
package sp_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;

endpackage

// File: rtl/burst_counter.sv
// burst_counter
// Holds the current RAM address and the remaining beat count of a burst.
//   clk, rst : clock and synchronous active-high reset
//   load_i   : capture addr_i / len_i as the new burst
//   step_i   : one beat done; address increments (wrapping), count decrements
//   addr_i   : burst start address
//   len_i    : beats minus one
//   addr_o   : current beat address
//   last_o   : high when the current beat is the final one
module burst_counter
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Load has priority; the address wraps naturally at 2^ADDR_W.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = len_i;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/sp_ram_master.sv
// sp_ram_master
// Initiator-side controller for a single-port RAM with a shared data bus.
//   clk, rst              : clock and synchronous active-high reset
//   req_valid/req_ready   : burst request handshake (ready only in IDLE)
//   req_wr, req_addr,
//   req_len               : burst direction, start address, beats minus one
//   wdata_valid/ready,
//   wdata                 : write beat stream
//   rdata_valid, rdata    : registered read beat stream (no backpressure)
//   done                  : one-cycle pulse at burst completion
//   en, wr, adder, data   : RAM pins; data is driven only while en & wr
module sp_ram_master
  import sp_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              en,
  output logic              wr,
  output logic [ADDR_W-1:0] adder,
  inout  wire  [DATA_W-1:0] data
);

  state_e            state_q;
  logic              accept;
  logic              step;
  logic              last;
  logic [ADDR_W-1:0] addr;
  logic              writeBeat;

  // Marks the cycle in which the RAM is driving the bus for us.
  logic              driveFlag_q;
  // Marks that the RAM drive cycle in flight carries the final read beat.
  logic              lastRead_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdataValid_q;
  logic              done_q;

  // Every RAM-facing signal is forced quiet while rst is high, so an
  // abandoned burst stops touching the RAM in the very cycle reset appears.
  assign accept    = !rst && (state_q == IDLE) && req_valid;
  assign writeBeat = !rst && (state_q == WRITE) && wdata_valid;
  assign step      = writeBeat || (!rst && (state_q == READ));

  burst_counter #(
    .ADDR_W (ADDR_W)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .step_i (step),
    .addr_i (req_addr),
    .len_i  (req_len),
    .addr_o (addr),
    .last_o (last)
  );

  assign req_ready   = !rst && (state_q == IDLE);
  assign wdata_ready = !rst && (state_q == WRITE);
  assign en          = writeBeat || (!rst && (state_q == READ));
  assign wr          = !rst && (state_q == WRITE);
  assign adder       = (!rst && (state_q == WRITE || state_q == READ)) ? addr : '0;
  assign data        = (en && wr) ? wdata : 'z;

  // FSM plus read capture. A read issued in cycle k is driven by the RAM in
  // k+1 (driveFlag_q high) and lands in rdata at the end of k+1, so done for a
  // read is delayed through lastRead_q to coincide with the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      driveFlag_q  <= 1'b0;
      lastRead_q   <= 1'b0;
      rdata_q      <= '0;
      rdataValid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      driveFlag_q  <= (state_q == READ);
      lastRead_q   <= (state_q == READ) && last;
      rdataValid_q <= driveFlag_q;
      if (driveFlag_q) begin
        rdata_q <= data;
      end
      done_q <= lastRead_q;

      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q <= req_wr ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wdata_valid && last) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        READ: begin
          if (last) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;
  assign done        = done_q;

endmodule
